// File: rtl/pong_renderer.sv
// Pong game renderer: game state advances once per frame in vertical blank; rgb/HS_out/VS_out are registered, 1 cycle after inputs.
// No backpressure (pixel stream). Optional score bar and hit counter behind `HIT_COUNTER_EN.
module pong_renderer #(
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int PADDLE_W    = 64,
  parameter int PADDLE_Y    = 464,
  parameter int PADDLE_STEP = 4,
  parameter int MISS_FRAMES = 60
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       pixelEN,
  input  logic       HS,
  input  logic       VS,
  input  logic [9:0] addrH,
  input  logic [9:0] addrV,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [2:0] rgb,
  output logic       HS_out,
  output logic       VS_out
);

  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] SP     = 11'(SPEED);
  localparam logic [10:0] PW     = 11'(PADDLE_W);
  localparam logic [10:0] PY     = 11'(PADDLE_Y);
  localparam logic [10:0] PSTEP  = 11'(PADDLE_STEP);
  localparam logic [10:0] H_MAX  = 11'd640;
  localparam logic [10:0] V_MAX  = 11'd480;
  localparam logic [9:0]  BX0    = 10'((640 - BALL_SIZE) / 2);
  localparam logic [9:0]  BY0    = 10'((480 - BALL_SIZE) / 2);
  localparam logic [9:0]  PX0    = 10'((640 - PADDLE_W) / 2);
  localparam logic [10:0] PX_MAX = 11'(640 - PADDLE_W);
  localparam logic [5:0]  MISS_LAST = 6'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {SERVE, PLAY, MISS} state_t;

  state_t     state, state_n;
  logic [9:0] bx, by, px, bx_n, by_n, px_n, px_moved;
  logic       dx, dy, dx_n, dy_n;
  logic [5:0] miss_cnt, miss_cnt_n;
  logic       vs_d, tick, hit;
  logic [10:0] bx11, by11, px11, ah, av;
  logic       in_ball, in_pad, in_bar;
  logic [2:0] pix;
`ifdef HIT_COUNTER_EN
  logic [7:0] hits, hits_n;
`endif

  assign tick = ~vs_d & VS;
  assign bx11 = {1'b0, bx};
  assign by11 = {1'b0, by};
  assign px11 = {1'b0, px};
  assign ah   = {1'b0, addrH};
  assign av   = {1'b0, addrV};

  assign hit = dy && (by11 + BS <= PY) && (by11 + BS + SP >= PY) &&
               (bx11 + BS > px11) && (bx11 < px11 + PW);

  always_comb begin
    px_moved = px;
    if (btn_left && !btn_right)
      px_moved = (px11 < PSTEP) ? 10'd0 : 10'(px11 - PSTEP);
    else if (btn_right && !btn_left)
      px_moved = (px11 + PSTEP > PX_MAX) ? PX_MAX[9:0] : 10'(px11 + PSTEP);
  end

  always_comb begin
    state_n    = state;
    bx_n       = bx;
    by_n       = by;
    dx_n       = dx;
    dy_n       = dy;
    px_n       = px;
    miss_cnt_n = miss_cnt;
`ifdef HIT_COUNTER_EN
    hits_n     = hits;
`endif
    if (tick) begin
      case (state)
        SERVE: begin
          px_n = px_moved;
          if (btn_left || btn_right) state_n = PLAY;
        end
        PLAY: begin
          px_n = px_moved;
          // A miss freezes the whole ball (both axes) where it fell out.
          if (dy && !hit && (by11 + BS + SP >= V_MAX)) begin
            state_n    = MISS;
            miss_cnt_n = 6'd0;
          end else begin
            if (dx) begin
              if (bx11 + BS + SP > H_MAX) begin
                bx_n = 10'(H_MAX - BS);
                dx_n = 1'b0;
              end else bx_n = 10'(bx11 + SP);
            end else begin
              if (bx11 < SP) begin
                bx_n = 10'd0;
                dx_n = 1'b1;
              end else bx_n = 10'(bx11 - SP);
            end
            if (!dy) begin
              if (by11 < SP) begin
                by_n = 10'd0;
                dy_n = 1'b1;
              end else by_n = 10'(by11 - SP);
            end else if (hit) begin
              by_n = 10'(PY - BS);
              dy_n = 1'b0;
`ifdef HIT_COUNTER_EN
              if (hits < 8'd80) hits_n = hits + 8'd1;
`endif
            end else by_n = 10'(by11 + SP);
          end
        end
        MISS: begin
          if (miss_cnt == MISS_LAST) begin
            state_n = SERVE;
            bx_n    = BX0;
            by_n    = BY0;
            dx_n    = 1'b1;
            dy_n    = 1'b0;
`ifdef HIT_COUNTER_EN
            hits_n  = 8'd0;
`endif
          end else miss_cnt_n = miss_cnt + 6'd1;
        end
        default: state_n = SERVE;
      endcase
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state    <= SERVE;
      bx       <= BX0;
      by       <= BY0;
      dx       <= 1'b1;
      dy       <= 1'b0;
      px       <= PX0;
      miss_cnt <= 6'd0;
      vs_d     <= 1'b1;
`ifdef HIT_COUNTER_EN
      hits     <= 8'd0;
`endif
    end else begin
      state    <= state_n;
      bx       <= bx_n;
      by       <= by_n;
      dx       <= dx_n;
      dy       <= dy_n;
      px       <= px_n;
      miss_cnt <= miss_cnt_n;
      vs_d     <= VS;
`ifdef HIT_COUNTER_EN
      hits     <= hits_n;
`endif
    end
  end

  assign in_ball = (ah >= bx11) && (ah < bx11 + BS) && (av >= by11) && (av < by11 + BS);
  assign in_pad  = (ah >= px11) && (ah < px11 + PW) && (av >= PY) && (av < PY + 11'd8);
`ifdef HIT_COUNTER_EN
  assign in_bar  = (av < 11'd8) && (ah < {hits, 3'b000});
`else
  assign in_bar  = 1'b0;
`endif

  always_comb begin
    pix = (state == MISS) ? 3'b100 : 3'b000;
    if (!pixelEN)     pix = 3'b000;
    else if (in_ball) pix = 3'b111;
    else if (in_pad)  pix = 3'b010;
    else if (in_bar)  pix = 3'b001;
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      rgb    <= 3'b000;
      HS_out <= 1'b1;
      VS_out <= 1'b1;
    end else begin
      rgb    <= pix;
      HS_out <= HS;
      VS_out <= VS;
    end
  end

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: vector table for rendering/sync alignment plus frame-tick sequences for play, hit, miss and clamps.
module tb_pong_renderer;
  logic       vgaclk = 1'b0;
  logic       reset, pixelEN, HS, VS, btn_left, btn_right;
  logic [9:0] addrH, addrV;
  logic [2:0] rgb;
  logic       HS_out, VS_out;

  always #20 vgaclk = ~vgaclk;

  pong_renderer dut (
    .vgaclk(vgaclk), .reset(reset), .pixelEN(pixelEN), .HS(HS), .VS(VS),
    .addrH(addrH), .addrV(addrV), .btn_left(btn_left), .btn_right(btn_right),
    .rgb(rgb), .HS_out(HS_out), .VS_out(VS_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference game state: 0 SERVE, 1 PLAY, 2 MISS
  int m_state, m_bx, m_by, m_dx, m_dy, m_px, m_cnt, m_hits;
  bit hit_seen = 0;

  typedef struct {
    logic     en, hs, vs;
    int       h, v;
    logic [2:0] e_rgb;
    logic     e_hs, e_vs;
  } vec_t;
  vec_t vecs[15];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 0;
    m_px = 288; m_cnt = 0; m_hits = 0;
  endtask

  task automatic model_tick(input bit bl, input bit br);
    int npx;
    npx = m_px;
    if (bl && !br) npx = (m_px < 4) ? 0 : m_px - 4;
    else if (br && !bl) npx = (m_px + 4 > 576) ? 576 : m_px + 4;
    if (m_state == 2) begin
      if (m_cnt == 59) begin
        m_state = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 0; m_hits = 0;
      end else m_cnt++;
    end else if (m_state == 0) begin
      if (bl || br) m_state = 1;
      m_px = npx;
    end else begin
      bit hit;
      hit = m_dy == 1 && m_by + 8 <= 464 && m_by + 10 >= 464 &&
            m_bx + 8 > m_px && m_bx < m_px + 64;
      if (m_dy == 1 && !hit && m_by + 10 >= 480) begin
        m_state = 2; m_cnt = 0;
      end else begin
        if (m_dx == 1) begin
          if (m_bx + 10 > 640) begin m_bx = 632; m_dx = 0; end else m_bx += 2;
        end else begin
          if (m_bx < 2) begin m_bx = 0; m_dx = 1; end else m_bx -= 2;
        end
        if (m_dy == 0) begin
          if (m_by < 2) begin m_by = 0; m_dy = 1; end else m_by -= 2;
        end else if (hit) begin
          m_by = 456; m_dy = 0; hit_seen = 1;
          if (m_hits < 80) m_hits++;
        end else m_by += 2;
      end
      m_px = npx;
    end
  endtask

  function automatic int exp_color(int h, int v);
    if (h >= m_bx && h < m_bx + 8 && v >= m_by && v < m_by + 8) return 7;
    if (h >= m_px && h < m_px + 64 && v >= 464 && v < 472) return 2;
`ifdef HIT_COUNTER_EN
    if (v < 8 && h < m_hits * 8) return 1;
`endif
    return (m_state == 2) ? 4 : 0;
  endfunction

  // all stimulus tasks start and end on a falling edge
  task automatic probe_exp(int h, int v, int exp);
    pixelEN = 1'b1; addrH = 10'(h); addrV = 10'(v);
    @(negedge vgaclk);
    check($sformatf("pix(%0d,%0d)", h, v), int'(rgb), exp);
    pixelEN = 1'b0;
  endtask

  task automatic probe(int h, int v);
    probe_exp(h, v, exp_color(h, v));
  endtask

  task automatic probe_all();
    probe(m_bx, m_by);
    probe(m_bx + 7, m_by + 7);
    if (m_bx > 0) probe(m_bx - 1, m_by);
    probe(m_px, 466);
    if (m_px + 64 < 640) probe(m_px + 64, 466);
    probe(3, 3);
  endtask

  task automatic do_tick(input bit bl, input bit br);
    VS = 1'b0; btn_left = bl; btn_right = br;
    @(negedge vgaclk);
    VS = 1'b1;
    @(negedge vgaclk);
    btn_left = 1'b0; btn_right = 1'b0;
    model_tick(bl, br);
  endtask

  initial begin
    bit bl, br;
    vecs[0]  = '{1, 1, 1, 316, 236, 3'b111, 1, 1};
    vecs[1]  = '{1, 0, 1, 323, 243, 3'b111, 0, 1};
    vecs[2]  = '{1, 1, 0, 324, 236, 3'b000, 1, 0};
    vecs[3]  = '{1, 1, 1, 315, 236, 3'b000, 1, 1};
    vecs[4]  = '{1, 1, 1, 316, 244, 3'b000, 1, 1};
    vecs[5]  = '{1, 1, 1, 316, 235, 3'b000, 1, 1};
    vecs[6]  = '{1, 1, 1, 288, 464, 3'b010, 1, 1};
    vecs[7]  = '{1, 0, 0, 351, 471, 3'b010, 0, 0};
    vecs[8]  = '{1, 1, 1, 352, 464, 3'b000, 1, 1};
    vecs[9]  = '{1, 1, 1, 287, 464, 3'b000, 1, 1};
    vecs[10] = '{1, 1, 1, 288, 472, 3'b000, 1, 1};
    vecs[11] = '{0, 1, 1, 316, 236, 3'b000, 1, 1};
    vecs[12] = '{0, 0, 1, 288, 464, 3'b000, 0, 1};
    vecs[13] = '{1, 1, 1,   0,   0, 3'b000, 1, 1};
    vecs[14] = '{1, 1, 1, 639, 479, 3'b000, 1, 1};

    reset = 1'b1; pixelEN = 1'b0; HS = 1'b0; VS = 1'b0;
    addrH = '0; addrV = '0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (3) @(negedge vgaclk);
    check("reset_rgb", int'(rgb), 0);
    check("reset_hs", int'(HS_out), 1);
    check("reset_vs", int'(VS_out), 1);
    HS = 1'b1; VS = 1'b1;
    @(negedge vgaclk);
    reset = 1'b0;
    model_reset();
    @(negedge vgaclk);

    // rendering and sync alignment in SERVE
    for (int i = 0; i < 15; i++) begin
      pixelEN = vecs[i].en; HS = vecs[i].hs; VS = vecs[i].vs;
      addrH = 10'(vecs[i].h); addrV = 10'(vecs[i].v);
      @(negedge vgaclk);
      check($sformatf("vec%0d_rgb", i), int'(rgb), int'(vecs[i].e_rgb));
      check($sformatf("vec%0d_hs", i), int'(HS_out), int'(vecs[i].e_hs));
      check($sformatf("vec%0d_vs", i), int'(VS_out), int'(vecs[i].e_vs));
    end
    pixelEN = 1'b0; HS = 1'b1; VS = 1'b1;
    @(negedge vgaclk);

    // serve with right button for 10 frames
    for (int t = 0; t < 10; t++) begin
      do_tick(0, 1);
      probe_all();
    end
    probe_exp(328, 464, 3'b010);
    probe_exp(327, 464, 3'b000);
    probe_exp(334, 218, 3'b111);
    probe_exp(333, 218, 3'b000);

    // track the ball until the first paddle hit
    for (int t = 0; t < 1500 && !hit_seen; t++) begin
      bl = (m_px + 32 > m_bx + 6);
      br = (m_px + 32 + 2 < m_bx + 4);
      do_tick(bl, br);
      probe_all();
    end
    if (hit_seen) begin
      probe_exp(m_bx, 456, 3'b111);
      probe_exp(m_bx, 455, 3'b000);
`ifdef HIT_COUNTER_EN
      probe_exp(0, 0, 3'b001);
      probe_exp(7, 7, 3'b001);
      probe_exp(8, 0, 3'b000);
`endif
    end

    // park paddle left until the ball falls out
    for (int t = 0; t < 2000 && m_state != 2; t++) begin
      do_tick(1, 0);
      probe_all();
    end
    if (m_state == 2) begin
      probe_exp(600, 100, 3'b100);
      for (int i = 1; i <= 60; i++) begin
        do_tick(0, 0);
        probe_exp(600, 100, (i < 60) ? 3'b100 : 3'b000);
        probe_all();
      end
      probe_exp(316, 236, 3'b111);
      probe_exp(323, 243, 3'b111);
      probe_exp(324, 243, 3'b000);
      probe_exp(0, 0, 3'b000);
    end

    // paddle clamps and both-button hold
    for (int t = 0; t < 160; t++) begin
      do_tick(0, 1);
      probe_all();
    end
    probe_exp(576, 464, 3'b010);
    probe_exp(575, 464, 3'b000);
    probe_exp(639, 471, 3'b010);
    for (int t = 0; t < 3; t++) begin
      do_tick(1, 1);
      probe_all();
    end
    probe_exp(576, 466, 3'b010);
    probe_exp(575, 466, 3'b000);
    for (int t = 0; t < 160; t++) begin
      do_tick(1, 0);
      probe_all();
    end
    probe_exp(0, 464, 3'b010);
    probe_exp(63, 471, 3'b010);
    probe_exp(64, 464, 3'b000);

    // asynchronous reset in the middle of a line
    pixelEN = 1'b1; addrH = 10'(m_bx); addrV = 10'(m_by); HS = 1'b0; VS = 1'b0;
    @(negedge vgaclk);
    check("pre_reset_rgb", int'(rgb), 7);
    check("pre_reset_hs", int'(HS_out), 0);
    #5 reset = 1'b1;
    #1;
    check("mid_reset_rgb", int'(rgb), 0);
    check("mid_reset_hs", int'(HS_out), 1);
    check("mid_reset_vs", int'(VS_out), 1);
    pixelEN = 1'b0; HS = 1'b1;
    repeat (2) @(negedge vgaclk);
    reset = 1'b0;
    model_reset();
    btn_right = 1'b1;
    @(negedge vgaclk);
    VS = 1'b1;
    @(negedge vgaclk);
    btn_right = 1'b0;
    model_tick(0, 1);
    probe_exp(292, 464, 3'b010);
    probe_exp(291, 464, 3'b000);
    probe_exp(316, 236, 3'b111);
    do_tick(0, 0);
    probe_exp(318, 234, 3'b111);
    probe_exp(317, 234, 3'b000);
    probe_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
